// File: rtl/pcap_pkg.sv
// Shared types and constants for the pcap byte-stream parser.
package pcap_pkg;

  typedef enum logic [1:0] {
    GHDR,
    RHDR,
    PAYLOAD,
    ERR
  } pcap_state_t;

  localparam int unsigned GHDR_BYTES = 24;
  localparam int unsigned RHDR_BYTES = 16;

  localparam logic [31:0] MAGIC_US = 32'ha1b2c3d4;
  localparam logic [31:0] MAGIC_NS = 32'ha1b23c4d;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/pcap_field_asm.sv
// Assembles 32-bit header fields from a byte stream; word includes the byte
// currently being shifted in so a field can be captured on its final byte.
module pcap_field_asm
  import pcap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  input  logic        swap,
  output logic [31:0] word
);

  logic [23:0] sr;
  logic [31:0] nxt;

  // nxt holds bytes in stream order: first byte received is the MSB.
  assign nxt  = {sr, in_byte};
  assign word = swap ? nxt : bswap32(nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= nxt[23:0];
    end
  end

endmodule

// File: rtl/pcap_stream_parser.sv
// Strips pcap global/record headers from a byte stream and emits framed
// payload bytes with per-record timestamp/length sideband.
module pcap_stream_parser
  import pcap_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16384,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  input  logic             m_ready,
  output logic [31:0]      rec_ts_sec,
  output logic [31:0]      rec_ts_usec,
  output logic [LEN_W-1:0] rec_len,
  output logic             nsec_mode,
  output logic [31:0]      rec_count,
  output logic             err
);

  pcap_state_t      state, state_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             acc;
  logic             swap_q;
  logic [31:0]      field;
  logic [31:0]      ts_sec_h, ts_usec_h, len_h;
  logic             magic_ok;
  logic             pay_last;

  // In GHDR the assembler is forced to stream order so the magic can be
  // matched against both byte orders.
  pcap_field_asm u_asm (
    .clk      (clk),
    .rst      (rst),
    .shift_en (acc),
    .in_byte  (s_data),
    .swap     ((state == GHDR) || swap_q),
    .word     (field)
  );

  assign magic_ok = (field == MAGIC_US) || (field == MAGIC_NS) ||
                    (bswap32(field) == MAGIC_US) || (bswap32(field) == MAGIC_NS);
  assign pay_last = (cnt == rec_len - 1'b1);
  assign err      = (state == ERR);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    s_ready = 1'b0;
    if (!rst && state != ERR) s_ready = !m_valid || m_ready;
    acc = s_valid && s_ready;
    if (acc) begin
      case (state)
        GHDR: begin
          cnt_d = cnt + 1'b1;
          if (cnt == LEN_W'(3) && !magic_ok) begin
            state_d = ERR;
          end else if (cnt == LEN_W'(GHDR_BYTES - 1)) begin
            state_d = RHDR;
            cnt_d   = '0;
          end
        end
        RHDR: begin
          cnt_d = cnt + 1'b1;
          if (cnt == LEN_W'(RHDR_BYTES - 1)) begin
            cnt_d = '0;
            if (len_h > 32'(MAX_LEN)) state_d = ERR;
            else if (len_h != '0)     state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          cnt_d = cnt + 1'b1;
          if (pay_last) begin
            state_d = RHDR;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GHDR;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      swap_q      <= 1'b0;
      nsec_mode   <= 1'b0;
      ts_sec_h    <= '0;
      ts_usec_h   <= '0;
      len_h       <= '0;
      rec_ts_sec  <= '0;
      rec_ts_usec <= '0;
      rec_len     <= '0;
      rec_count   <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (acc) begin
        case (state)
          GHDR: begin
            if (cnt == LEN_W'(3)) begin
              swap_q    <= (field == MAGIC_US) || (field == MAGIC_NS);
              nsec_mode <= (field == MAGIC_NS) || (bswap32(field) == MAGIC_NS);
            end
          end
          RHDR: begin
            if (cnt == LEN_W'(3))  ts_sec_h  <= field;
            if (cnt == LEN_W'(7))  ts_usec_h <= field;
            if (cnt == LEN_W'(11)) len_h     <= field;
            if (cnt == LEN_W'(RHDR_BYTES - 1)) begin
              rec_ts_sec  <= ts_sec_h;
              rec_ts_usec <= ts_usec_h;
              rec_len     <= len_h[LEN_W-1:0];
              if (len_h == '0) rec_count <= rec_count + 1'b1;
            end
          end
          PAYLOAD: begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_first <= (cnt == '0);
            m_last  <= pay_last;
            if (pay_last) rec_count <= rec_count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pcap_stream_parser.md
Name: pcap_stream_parser

Overview:
- Synthesizable counterpart to the pcap writer: consumes the raw byte stream of a pcap file and emits the packet payloads as a byte stream framed by first/last flags.
- Strips the 24-byte global header and each 16-byte record header.
- Detects file endianness from the magic number and exposes per-record timestamp and length sideband.
- Sits between a file/DMA byte source and packet-processing logic in benches and FPGA replay designs.

Parameters:
- MAX_LEN, 16384, largest accepted incl_len in bytes; larger values are a format error.
- LEN_W, 16, width of the length sideband and payload byte counter; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_data  in  8  pcap file byte
- s_valid  in  1  s_data valid
- s_ready  out  1  parser accepts s_data this cycle
- m_data  out  8  payload byte
- m_valid  out  1  m_data valid
- m_first  out  1  first payload byte of a record
- m_last  out  1  last payload byte of a record
- m_ready  in  1  downstream accepts
- rec_ts_sec  out  32  ts_sec of the current record, host-order corrected
- rec_ts_usec  out  32  ts_usec/ts_nsec of the current record
- rec_len  out  LEN_W  incl_len of the current record
- nsec_mode  out  1  magic was a1b23c4d (nanosecond timestamps)
- rec_count  out  32  records fully parsed, wraps at 2**32
- err  out  1  sticky format error

Behaviour:
- Reset values:
  - All outputs 0; state is GHDR; byte counter is 0.
  - s_ready becomes 1 in the first cycle after rst deasserts.
  - Reset mid-record discards everything, including a pending m_valid beat.
- Transfer rules:
  - Input transfer occurs when s_valid && s_ready.
  - Output transfer occurs when m_valid && m_ready.
  - m_data/m_first/m_last are held stable while m_valid && !m_ready.
- GHDR (24 bytes):
  - Bytes 0-3 form the magic.
  - d4 c3 b2 a1 or 4d 3c b2 a1: little-endian, swap=0.
  - a1 b2 c3 d4 or a1 b2 3c 4d: big-endian, swap=1.
  - nsec_mode=1 for the 3c4d variants.
  - Any other magic: go to ERR when byte 3 is accepted.
  - Bytes 4-23 are ignored. After byte 23, go to RHDR with counter cleared.
- RHDR (16 bytes):
  - Fields in order: ts_sec, ts_usec, incl_len, orig_len. Assemble each per swap.
  - On acceptance of byte 15, load rec_ts_sec, rec_ts_usec and rec_len = incl_len[LEN_W-1:0].
  - If incl_len > MAX_LEN: ERR.
  - Else if incl_len == 0: rec_count += 1, stay in RHDR, emit no beats.
  - Else: PAYLOAD.
  - orig_len is ignored.
- PAYLOAD:
  - s_ready = !m_valid || m_ready (one-stage output register, no bubble at full rate).
  - Each accepted byte is registered onto m_data with m_valid=1 in the next cycle.
  - m_first=1 on the byte at count 0; m_last=1 on the byte at count rec_len-1.
  - Accepting the last byte: rec_count += 1 and go to RHDR. The next record header may be accepted while the final beat is still stalled, because the output register holds it.
- Header states:
  - s_ready=1 unless the output register holds an unaccepted beat; m_valid drops after that beat transfers.
  - Latency: payload byte in cycle N appears on m_valid in cycle N+1.
- ERR:
  - Terminal until rst.
  - err=1, s_ready=0; any pending output beat still drains.
- Sideband: rec_* change only on RHDR byte 15 and are stable for the whole payload.
- Truncated input (s_valid stops) simply stalls; there is no timeout.

Decomposition:
- Package pcap_pkg holds:
  - state enum {GHDR, RHDR, PAYLOAD, ERR};
  - GHDR_BYTES=24, RHDR_BYTES=16;
  - magic constants MAGIC_US=32'ha1b2c3d4 and MAGIC_NS=32'ha1b23c4d.
- One sub-module, pcap_field_asm: shifts bytes into a 32-bit word and outputs it byte-swapped or not according to swap. It is reused for the magic and the three record fields.

Test Plan:
- LE file, 1 record, incl_len=4, payload 11 22 33 44, m_ready=1 -> 4 beats 11..44, m_first on 11, m_last on 44, rec_len=4, rec_count=1, err=0.
- BE magic a1 b2 c3 d4, ts_sec bytes 00 00 01 00 -> rec_ts_sec=256, payload passes unchanged.
- Two back-to-back records of lengths 60 and 1 with m_ready toggling 1/0 every cycle -> 61 beats in order with no loss or duplication, the 1-byte record has m_first=m_last=1, rec_count=2.
- Record with incl_len=0 followed by incl_len=2 -> no beat for the first, 2 beats for the second, rec_count=2.
- Bad magic 00 00 00 00 -> err=1 and s_ready=0 from the cycle after byte 3; incl_len=MAX_LEN+1 -> err=1 with no payload beats.
- rst asserted mid-payload of a 100-byte record, then a fresh file -> all outputs 0 after the reset cycle, the new file parses correctly, rec_count restarts at 0.
